// File: rtl/packer_arb_pkg.sv
// Shared types for the packer arbiter: FSM state encoding and the index width helper.
package packer_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/packer_arbiter_rr_pick.sv
// Combinational round-robin search: first requesting index at or above the pointer, wrapping.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [IDW-1:0] o_idx,
  output logic           o_valid
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  int             w_off;
  int             w_sum;

  // Rotating the doubled vector puts the pointer position at bit 0.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    o_valid = 1'b0;
    w_off   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_valid = 1'b1;
        w_off   = k;
      end
    end
    w_sum = int'(i_ptr) + w_off;
    if (w_sum >= N) begin
      w_sum = w_sum - N;
    end
    o_idx = IDW'(w_sum);
  end

endmodule

// File: rtl/packer_arbiter.sv
// Round-robin arbiter that locks one requester onto the packer input for a whole group of beats.
// Optional group completion counter enabled by defining PACKER_ARB_GROUP_CNT_EN.
module packer_arbiter
  import packer_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int IN_WIDTH    = 64,
  parameter int GROUP_BEATS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            s_write_req,
  output logic [NUM_REQ-1:0]            s_write_ready,
  input  logic [NUM_REQ*IN_WIDTH-1:0]   s_write_data,
  output logic                          m_write_req,
  input  logic                          m_write_ready,
  output logic [IN_WIDTH-1:0]           m_write_data,
  output logic [idWidth(NUM_REQ)-1:0]   m_grant_id
`ifdef PACKER_ARB_GROUP_CNT_EN
  ,
  output logic [31:0]                   grp_count
`endif
);

  localparam int IDW = idWidth(NUM_REQ);
  localparam int BW  = idWidth(GROUP_BEATS);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(GROUP_BEATS - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  state_t         r_state;
  state_t         w_next;
  logic [IDW-1:0] r_grant;
  logic [IDW-1:0] r_ptr;
  logic [BW-1:0]  r_beat;
  logic [IDW-1:0] w_pick;
  logic           w_any;
  logic           w_beat;
  logic           w_last;

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_pick (
    .i_req   (s_write_req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick),
    .o_valid (w_any)
  );

  assign m_grant_id = r_grant;
  assign w_beat     = (r_state == LOCKED) && s_write_req[r_grant] && m_write_ready;
  assign w_last     = w_beat && (r_beat == LAST_BEAT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs are steered purely from the locked owner, so IDLE presents nothing to the packer.
  always_comb begin
    w_next        = r_state;
    m_write_req   = 1'b0;
    m_write_data  = '0;
    s_write_ready = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next = LOCKED;
        end
      end
      LOCKED: begin
        m_write_req            = s_write_req[r_grant];
        m_write_data           = s_write_data[r_grant*IN_WIDTH +: IN_WIDTH];
        s_write_ready[r_grant] = m_write_ready;
        if (w_last) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant <= '0;
      r_ptr   <= '0;
      r_beat  <= '0;
    end else begin
      if ((r_state == IDLE) && w_any) begin
        r_grant <= w_pick;
      end
      if (w_beat) begin
        if (w_last) begin
          r_beat <= '0;
          r_ptr  <= (r_grant == LAST_ID) ? '0 : r_grant + 1'b1;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
    end
  end

`ifdef PACKER_ARB_GROUP_CNT_EN
  logic [31:0] r_grp_count;

  assign grp_count = r_grp_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grp_count <= '0;
    end else if (w_last) begin
      r_grp_count <= r_grp_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_packer_arbiter.sv
// Self-checking bench for packer_arbiter: directed scenarios plus randomized traffic against a group-level model.
module tb_packer_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int GB = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   sReq = '0;
  logic [N-1:0]   sReady;
  logic [N*W-1:0] sData = '0;
  logic           mReq;
  logic           mReady = 1'b0;
  logic [W-1:0]   mData;
  logic [1:0]     gid;
`ifdef PACKER_ARB_GROUP_CNT_EN
  logic [31:0]    grpCount;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Group-level model: who owns the packer, how many beats of the group are done, where the search starts.
  bit          mBusy = 1'b0;
  int          mOwner = 0;
  int          mPtr = 0;
  int          mDone = 0;
  logic [31:0] mGroups = '0;
  logic           eReq;
  logic [W-1:0]   eData;
  logic [N-1:0]   eRdy;
  int             eGid;
  bit             found;

  packer_arbiter #(
    .NUM_REQ     (N),
    .IN_WIDTH    (W),
    .GROUP_BEATS (GB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_write_req   (sReq),
    .s_write_ready (sReady),
    .s_write_data  (sData),
    .m_write_req   (mReq),
    .m_write_ready (mReady),
    .m_write_data  (mData),
    .m_grant_id    (gid)
`ifdef PACKER_ARB_GROUP_CNT_EN
    ,
    .grp_count     (grpCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change one tick after the rising edge; the task returns mid-cycle, ready for literal checks.
  task automatic applyStimulus(input logic [N-1:0] req, input logic rdy);
    sReq   = req;
    mReady = rdy;
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setData(input int idx, input logic [W-1:0] val);
    sData[idx*W +: W] = val;
  endtask

  task automatic doReset();
    sReq  = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Compare process: checks DUT outputs against the model every cycle, then advances the model.
  always @(negedge clk) begin
    if (!reset) begin
      mBusy   = 1'b0;
      mOwner  = 0;
      mPtr    = 0;
      mDone   = 0;
      mGroups = '0;
    end
    eReq  = 1'b0;
    eData = '0;
    eRdy  = '0;
    eGid  = mOwner;
    if (mBusy) begin
      eReq  = sReq[mOwner];
      eData = sData[mOwner*W +: W];
      if (mReady) eRdy[mOwner] = 1'b1;
    end
    checkOutput("cyc_m_write_req", W'(mReq), W'(eReq));
    checkOutput("cyc_m_write_data", mData, eData);
    checkOutput("cyc_s_write_ready", W'(sReady), W'(eRdy));
    checkOutput("cyc_m_grant_id", W'(gid), W'(eGid));
`ifdef PACKER_ARB_GROUP_CNT_EN
    checkOutput("cyc_grp_count", W'(grpCount), W'(mGroups));
`endif
    if (reset) begin
      if (mBusy) begin
        if (sReq[mOwner] && mReady) begin
          mDone++;
          if (mDone == GB) begin
            mBusy   = 1'b0;
            mDone   = 0;
            mPtr    = (mOwner + 1) % N;
            mGroups = mGroups + 32'd1;
          end
        end
      end else if (sReq != '0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && sReq[(mPtr + k) % N]) begin
            mOwner = (mPtr + k) % N;
            found  = 1'b1;
          end
        end
        mBusy = 1'b1;
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    tick();
    checkOutput("reset_grant", W'(gid), 64'd0);
    checkOutput("reset_m_write_req", W'(mReq), 64'd0);
    checkOutput("reset_s_write_ready", W'(sReady), 64'd0);
    reset = 1'b1;

    // Lone requester 2 with words A then B.
    setData(2, 64'hAAAA_0000_AAAA_0001);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("idle_no_transfer", W'(mReq), 64'd0);
    tick();
    applyStimulus(4'b0100, 1'b1);
    checkOutput("lone_grant", W'(gid), 64'd2);
    checkOutput("lone_word_a", mData, 64'hAAAA_0000_AAAA_0001);
    checkOutput("lone_ready", W'(sReady), 64'h4);
    tick();
    setData(2, 64'hBBBB_0000_BBBB_0002);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("lone_word_b", mData, 64'hBBBB_0000_BBBB_0002);
    tick();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("lone_back_idle", W'(mReq), 64'd0);
    checkOutput("model_rr_ptr", W'(mPtr), 64'd3);
    tick();
    applyStimulus(4'b1111, 1'b1);
    tick();
    applyStimulus(4'b1111, 1'b1);
    checkOutput("ptr_after_lone", W'(gid), 64'd3);
    tick();
    doReset();

    // All requesters busy: I,L,L repeating with grants 0,1,2,3,0.
    for (int c = 0; c < 15; c++) begin
      applyStimulus(4'b1111, 1'b1);
      if (c % 3 == 0) begin
        checkOutput("rr_bubble", W'(mReq), 64'd0);
      end else begin
        checkOutput("rr_order", W'(gid), W'((c / 3) % 4));
        checkOutput("rr_active", W'(mReq), 64'd1);
      end
      tick();
    end
    doReset();

    // Owner 1 drops its request after beat 0 while requester 3 waits.
    applyStimulus(4'b0010, 1'b1);
    tick();
    applyStimulus(4'b1010, 1'b1);
    checkOutput("drop_grant", W'(gid), 64'd1);
    tick();
    applyStimulus(4'b1000, 1'b1);
    checkOutput("drop_hold_grant", W'(gid), 64'd1);
    checkOutput("drop_no_req", W'(mReq), 64'd0);
    tick();
    applyStimulus(4'b1010, 1'b1);
    checkOutput("drop_second_beat", W'(gid), 64'd1);
    tick();
    applyStimulus(4'b1000, 1'b1);
    checkOutput("drop_bubble", W'(mReq), 64'd0);
    tick();
    applyStimulus(4'b1000, 1'b1);
    checkOutput("drop_next_grant", W'(gid), 64'd3);
    tick();
    applyStimulus(4'b1000, 1'b1);
    tick();

    // Packer stalls for five cycles mid-group.
    setData(0, 64'hC0C0_C0C0_1234_5678);
    applyStimulus(4'b0001, 1'b1);
    tick();
    applyStimulus(4'b0001, 1'b1);
    checkOutput("stall_word", mData, 64'hC0C0_C0C0_1234_5678);
    tick();
    for (int s = 0; s < 5; s++) begin
      applyStimulus(4'b0001, 1'b0);
      checkOutput("stall_ready_low", W'(sReady), 64'd0);
      checkOutput("stall_data_held", mData, 64'hC0C0_C0C0_1234_5678);
      checkOutput("stall_grant", W'(gid), 64'd0);
      tick();
    end
    applyStimulus(4'b0001, 1'b1);
    checkOutput("stall_resume", W'(sReady), 64'h1);
    tick();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("stall_group_done", W'(mReq), 64'd0);
    tick();

    // Reset mid-group must clear outputs without a clock edge.
    doReset();
    applyStimulus(4'b0100, 1'b1);
    tick();
    applyStimulus(4'b0100, 1'b1);
    tick();
    sReq   = 4'b0100;
    mReady = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_m_write_req", W'(mReq), 64'd0);
    checkOutput("async_s_write_ready", W'(sReady), 64'd0);
    checkOutput("async_grant", W'(gid), 64'd0);
    checkOutput("async_data", mData, 64'd0);
    tick();
    reset = 1'b1;
    applyStimulus(4'b0110, 1'b1);
    tick();
    applyStimulus(4'b0110, 1'b1);
    checkOutput("post_reset_ptr0", W'(gid), 64'd1);
    tick();

`ifdef PACKER_ARB_GROUP_CNT_EN
    doReset();
    for (int c = 0; c < 9; c++) begin
      applyStimulus(4'b0001, 1'b1);
      tick();
    end
    applyStimulus(4'b0001, 1'b1);
    checkOutput("grp_count_three", W'(grpCount), 64'd3);
    force dut.r_grp_count = 32'hFFFF_FFFE;
    release dut.r_grp_count;
    mGroups = 32'hFFFF_FFFE;
    tick();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(4'b0001, 1'b1);
      tick();
    end
    applyStimulus(4'b0001, 1'b1);
    checkOutput("grp_count_max", W'(grpCount), 64'hFFFF_FFFF);
    tick();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(4'b0001, 1'b1);
      tick();
    end
    applyStimulus(4'b0001, 1'b1);
    checkOutput("grp_count_wrap", W'(grpCount), 64'd0);
    tick();
`endif

    // Randomized traffic checked by the compare process.
    doReset();
    for (int r = 0; r < 400; r++) begin
      for (int i = 0; i < N; i++) begin
        setData(i, {$urandom, $urandom});
      end
      applyStimulus(N'({($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
                        ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4)}),
                    ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/packer_arbiter.md
PACKER_ARBITER -- requirements
Module: packer_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one data packer input.
REQ-002 The block SHALL have parameter IN_WIDTH, default 64, meaning the width of each requester word and of the packer input.
REQ-003 The block SHALL have parameter GROUP_BEATS, default 2, meaning the words per packed output word (the packer's OUT_WIDTH/IN_WIDTH, rounded up).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port s_write_req, input, NUM_REQ bits: per-requester word valid.
REQ-007 The block SHALL have port s_write_ready, output, NUM_REQ bits: per-requester word accept.
REQ-008 The block SHALL have port s_write_data, input, NUM_REQ*IN_WIDTH bits: requester i in bits [i*IN_WIDTH +: IN_WIDTH].
REQ-009 The block SHALL have port m_write_req, output, 1 bit: word valid to the packer.
REQ-010 The block SHALL have port m_write_ready, input, 1 bit: packer ready.
REQ-011 The block SHALL have port m_write_data, output, IN_WIDTH bits: word to the packer.
REQ-012 The block SHALL have port m_grant_id, output, clog2(NUM_REQ) bits (minimum 1): index of the current owner.

Function
REQ-013 The FSM SHALL have two states, IDLE and LOCKED.
REQ-014 In IDLE, when any s_write_req bit is high, the block SHALL register the round-robin winner into m_grant_id and enter LOCKED on the next edge; no word is transferred in that cycle.
REQ-015 The round-robin winner SHALL be the first requesting index at or above rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-016 In LOCKED, m_write_req SHALL equal s_write_req[m_grant_id], m_write_data SHALL equal the granted slice, and s_write_ready[m_grant_id] SHALL equal m_write_ready; all other s_write_ready bits SHALL be 0.
REQ-017 In IDLE, m_write_req, m_write_data and all s_write_ready bits SHALL be 0.
REQ-018 A beat SHALL be counted when state is LOCKED and s_write_req[m_grant_id] && m_write_ready.
REQ-019 The beat counter SHALL run 0..GROUP_BEATS-1; on the beat at GROUP_BEATS-1 it SHALL clear, the FSM SHALL return to IDLE, and rr_ptr SHALL become (m_grant_id+1) mod NUM_REQ.
REQ-020 The grant SHALL NOT change mid-group, even if the owner deasserts s_write_req or other requesters assert theirs.
REQ-021 Grant latency SHALL be 1 cycle from request to LOCKED; there SHALL be exactly one IDLE bubble between consecutive groups.
REQ-022 With GROUP_BEATS == 1, every beat SHALL end the group.

Reset
REQ-023 Assertion of reset (low) SHALL asynchronously force IDLE, beat counter 0, rr_ptr 0 and m_grant_id 0, abandoning any partial group; deassertion is synchronised externally.

Configuration
REQ-024 With PACKER_ARB_GROUP_CNT_EN defined, the block SHALL add output grp_count, 32 bits, reset 0, incremented on each group completion and wrapping at 2^32-1 to 0.
REQ-025 Without PACKER_ARB_GROUP_CNT_EN, the block SHALL have neither the port nor the counter logic.

Structure
REQ-026 Package packer_arb_pkg SHALL hold the FSM state typedef (IDLE, LOCKED) and the clog2 width helper.
REQ-027 The round-robin priority search SHALL be a combinational sub-module named rr_pick (inputs: request vector, pointer; outputs: winner index and any-valid flag).

Verification
REQ-028 The bench SHALL cover: NUM_REQ=4, GROUP_BEATS=2, only req[2] high with words A,B -> grant 2 after 1 cycle; m_write_data A then B; return to IDLE; rr_ptr=3.
REQ-029 The bench SHALL cover: all four requesters continuously high -> grants 0,1,2,3,0 in order, each holding exactly 2 beats, with one bubble between groups.
REQ-030 The bench SHALL cover: owner 1 drops req after beat 0 while req[3] is high -> grant stays 1 until its second beat; then grant 3.
REQ-031 The bench SHALL cover: m_write_ready low for 5 cycles mid-group -> no beat counted; s_write_ready[owner]=0; m_write_data held; group completes after ready returns.
REQ-032 The bench SHALL cover: reset pulsed low after beat 0 of a group -> outputs 0 immediately, without waiting for a clock edge; next grant uses rr_ptr 0.
REQ-033 The bench SHALL cover, with PACKER_ARB_GROUP_CNT_EN: 3 completed groups -> grp_count=3, and grp_count preset near wrap -> 0xFFFFFFFF then 0.
